ex_iter_stage: RTL and testbench

Parametrised execute stage with valid/ready handshakes on both sides. Single-cycle integer ops go through a combinational ALU. MUL/DIV ops run in an iterative shift-add/restoring core that takes many cycles. All results land in a one-entry EX/WB output register, which lets the stage stall against writeback. It sits between the ID/EX pipeline register and the WB stage and adds backpressure and flush support.

---
 rtl/ex_iter_pkg.sv | 33 +++
 rtl/ex_iter_md.sv | 121 ++++++++++++
 rtl/ex_iter_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_iter_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_iter_pkg.sv
// Shared types and helpers for the iterative execute stage.
// Contents:
//   ex_op_e     4-bit operation encoding presented on op_i
//   ex_state_e  stage sequencing states
//   is_md_op / is_div_op / is_rem_op / is_signed_div  op classification
package ex_iter_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DONE
  } ex_state_e;

  function automatic logic is_md_op(input ex_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div_op(input ex_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input ex_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input ex_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_iter_md.sv
// Iterative multiplier / restoring divider core.
// Build option: EX_ITER_DIV_EN adds the divider datapath; without it only
// MUL/MULHU are supported.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start          load operands and perform the first iteration this edge
//   kill           abandon the op in progress
//   op, a, b       operation and operands (sampled on start)
//   done           high in the cycle whose edge performs the last iteration
//   result         final result, stable once iterations stop
module ex_iter_md
  import ex_iter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start,
  input  logic              kill,
  input  ex_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PS_W  = DATA_W + MUL_BITS;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W / MUL_BITS - 1);

  // acc holds {high product, remaining multiplier} or {remainder, dividend/quotient}
  logic [2*DATA_W-1:0] acc, acc_cur, acc_next;
  logic [DATA_W-1:0]   opnd, opnd_cur;
  logic [CNT_W-1:0]    cnt, cnt_init;
  logic [PS_W-1:0]     partial, hi_sum;
  ex_op_e              op_q;

`ifdef EX_ITER_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);
  logic              a_neg, b_neg, neg_q, neg_r, ge;
  logic [DATA_W-1:0] a_mag, b_mag, diff, quo, rem;
  logic [DATA_W:0]   shifted;
  ex_op_e            op_cur;

  assign a_neg  = is_signed_div(op) && a[DATA_W-1];
  assign b_neg  = is_signed_div(op) && b[DATA_W-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign op_cur = start ? op : op_q;
  assign cnt_init = is_div_op(op) ? DIV_LAST : MUL_LAST;
`else
  assign cnt_init = MUL_LAST;
`endif

  // The first iteration happens on the start edge, straight from the operands.
  always_comb begin
    acc_cur  = start ? {{DATA_W{1'b0}}, b} : acc;
    opnd_cur = start ? a : opnd;
`ifdef EX_ITER_DIV_EN
    if (start && is_div_op(op)) begin
      acc_cur  = {{DATA_W{1'b0}}, a_mag};
      opnd_cur = b_mag;
    end
`endif
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc_cur[i]) partial = partial + (PS_W'(opnd_cur) << i);
    end
    hi_sum   = PS_W'(acc_cur[2*DATA_W-1:DATA_W]) + partial;
    acc_next = {hi_sum, acc_cur[DATA_W-1:MUL_BITS]};
`ifdef EX_ITER_DIV_EN
    shifted = {acc_cur[2*DATA_W-1:DATA_W], acc_cur[DATA_W-1]};
    ge      = (shifted >= {1'b0, opnd_cur});
    // Only the low bits matter: when ge is set the true difference fits.
    diff    = shifted[DATA_W-1:0] - opnd_cur;
    if (is_div_op(op_cur))
      acc_next = {ge ? diff : shifted[DATA_W-1:0], acc_cur[DATA_W-2:0], ge};
`endif
  end

  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
      op_q <= OP_ADD;
`ifdef EX_ITER_DIV_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (kill) begin
      cnt <= '0;
    end else if (start) begin
      acc  <= acc_next;
      opnd <= opnd_cur;
      op_q <= op;
      cnt  <= cnt_init;
`ifdef EX_ITER_DIV_EN
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
`endif
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    result = (op_q == OP_MULHU) ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
`ifdef EX_ITER_DIV_EN
    quo = acc[DATA_W-1:0];
    rem = acc[2*DATA_W-1:DATA_W];
    if (is_div_op(op_q))
      result = is_rem_op(op_q) ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
`endif
  end

endmodule

// File: rtl/ex_iter_stage.sv
// Execute stage: combinational ALU, iterative MUL/DIV, one-entry EX/WB register.
// Build option: EX_ITER_DIV_EN enables the divider; otherwise divide ops
// complete in one cycle flagged illegal with no write.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       ID/EX handshake
//   op_i, operand_a_i, operand_b_i, rd_addr_i, rd_we_i   op captured at accept
//   flush_i                       kill in-flight op and output entry
//   out_valid_o / out_ready_i     EX/WB handshake
//   out_rd_addr_o, out_wdata_o, out_we_o, out_illegal_o   registered result
//   busy_o                        iterative op in progress
//
// state   | meaning
// IDLE    | ready for a new op
// MUL     | multiplier iterating
// DIV     | divider iterating
// DONE    | iterative result waiting for the output register
module ex_iter_stage
  import ex_iter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 2,
  parameter int RADDR_W  = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  ex_op_e             op_i,
  input  logic [DATA_W-1:0]  operand_a_i,
  input  logic [DATA_W-1:0]  operand_b_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RADDR_W-1:0] out_rd_addr_o,
  output logic [DATA_W-1:0]  out_wdata_o,
  output logic               out_we_o,
  output logic               out_illegal_o,
  output logic               busy_o
);

  localparam int SH_W = $clog2(DATA_W);

  ex_state_e          state;
  logic               accept, to_mul, to_div, out_load, md_done;
  logic               single_we, single_ill, we_q;
  logic [DATA_W-1:0]  alu_res, single_data, md_result;
  logic [SH_W-1:0]    shamt;
  logic [RADDR_W-1:0] rd_q;

  assign shamt      = operand_b_i[SH_W-1:0];
  assign in_ready_o = (state == ST_IDLE) && (!out_valid_o || out_ready_i) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state != ST_IDLE);

  always_comb begin
    case (op_i)
      OP_ADD:  alu_res = operand_a_i + operand_b_i;
      OP_SUB:  alu_res = operand_a_i - operand_b_i;
      OP_AND:  alu_res = operand_a_i & operand_b_i;
      OP_OR:   alu_res = operand_a_i | operand_b_i;
      OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
      OP_SLL:  alu_res = operand_a_i << shamt;
      OP_SRL:  alu_res = operand_a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(operand_a_i) >>> shamt);
      OP_SLT:  alu_res = DATA_W'($signed(operand_a_i) < $signed(operand_b_i));
      OP_SLTU: alu_res = DATA_W'(operand_a_i < operand_b_i);
      default: alu_res = '0;
    endcase
  end

  // Decide whether the op finishes in one cycle or goes to the iterative core.
  always_comb begin
    single_data = alu_res;
    single_we   = rd_we_i;
    single_ill  = 1'b0;
    to_mul      = 1'b0;
    to_div      = 1'b0;
    if (is_md_op(op_i)) begin
      if (!is_div_op(op_i)) begin
        to_mul = 1'b1;
      end else begin
`ifdef EX_ITER_DIV_EN
        if (operand_b_i == '0)
          single_data = is_rem_op(op_i) ? operand_a_i : {DATA_W{1'b1}};
        else if (is_signed_div(op_i) && operand_a_i == {1'b1, {(DATA_W-1){1'b0}}}
                 && operand_b_i == {DATA_W{1'b1}})
          single_data = is_rem_op(op_i) ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
        else
          to_div = 1'b1;
`else
        single_data = '0;
        single_we   = 1'b0;
        single_ill  = 1'b1;
`endif
      end
    end
  end

  assign out_load = (accept && !to_mul && !to_div) ||
                    (state == ST_DONE && (!out_valid_o || out_ready_i));

  ex_iter_md #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) u_md (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start  (accept && (to_mul || to_div)),
    .kill   (flush_i),
    .op     (op_i),
    .a      (operand_a_i),
    .b      (operand_b_i),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      rd_q          <= '0;
      we_q          <= 1'b0;
      out_valid_o   <= 1'b0;
      out_rd_addr_o <= '0;
      out_wdata_o   <= '0;
      out_we_o      <= 1'b0;
      out_illegal_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      if (out_load)         out_valid_o <= 1'b1;
      else if (out_ready_i) out_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q <= rd_addr_i;
            we_q <= rd_we_i;
            if (to_mul) begin
              state <= ST_MUL;
            end else if (to_div) begin
              state <= ST_DIV;
            end else begin
              out_rd_addr_o <= rd_addr_i;
              out_wdata_o   <= single_data;
              out_we_o      <= single_we;
              out_illegal_o <= single_ill;
            end
          end
        end
        ST_MUL: if (md_done) state <= ST_DONE;
`ifdef EX_ITER_DIV_EN
        ST_DIV: if (md_done) state <= ST_DONE;
`endif
        ST_DONE: begin
          if (out_load) begin
            out_rd_addr_o <= rd_q;
            out_wdata_o   <= md_result;
            out_we_o      <= we_q;
            out_illegal_o <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_iter_stage.sv
module tb_ex_iter_stage;
  import ex_iter_pkg::*;

  localparam int DATA_W = 32, MUL_BITS = 2, RADDR_W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, rd_we = 1'b0, flush = 1'b0;
  logic out_valid, out_ready = 1'b1, out_we, out_ill, busy;
  ex_op_e op = OP_ADD;
  logic [DATA_W-1:0] opa = '0, opb = '0, out_wdata;
  logic [RADDR_W-1:0] rd = '0, out_rd;

  always #5 clk = ~clk;

  ex_iter_stage #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS), .RADDR_W(RADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .operand_a_i(opa), .operand_b_i(opb), .rd_addr_i(rd), .rd_we_i(rd_we),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rd_addr_o(out_rd), .out_wdata_o(out_wdata), .out_we_o(out_we),
    .out_illegal_o(out_ill), .busy_o(busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    ex_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  int   checks = 0, failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every consumed entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: actual wdata=0x%0h rd=%0d required no entry",
                 out_wdata, out_rd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("scoreboard {rd,we,ill,wdata}", {out_rd, out_we, out_ill, out_wdata},
            {mon_e.rd, mon_e.we, mon_e.ill, mon_e.d});
      end
    end
  end

  task automatic send(input ex_op_e o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, input logic we, input logic push,
                      input logic [31:0] ed, input logic ewe, input logic eill,
                      output int waited);
    exp_t e;
    in_valid = 1'b1; op = o; opa = a; opb = b; rd = r; rd_we = we;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1 within 100 cycles");
    end else if (push) begin
      e.d = ed; e.rd = r; e.we = ewe; e.ill = eill;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called at accept edge + 1; latency counts cycles until out_valid is seen.
  task automatic wait_out(output int lat, output int bz);
    lat = 1;
    bz  = 0;
    forever begin
      if (busy) bz++;
      if (out_valid || lat >= 100) break;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_done", {31'd0, (exp_q.size() == 0 && !out_valid)}, 1);
  endtask

  task automatic flush_mid(input ex_op_e o, input logic [31:0] a, input logic [31:0] b);
    int w;
    exp_t e;
    send(o, a, b, 5'd3, 1'b1, 1'b0, '0, 1'b0, 1'b0, w);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    in_valid = 1'b1; op = OP_ADD; opa = 32'd10; opb = 32'd20; rd = 5'd7; rd_we = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_after", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    @(negedge clk);
    chk("post_flush_in_ready", in_ready, 1);
    e.d = 32'd30; e.rd = 5'd7; e.we = 1'b1; e.ill = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("post_flush_accept_valid", out_valid, 1);
    drain();
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual sim time exceeded required bound");
    $fatal(1);
  end

  initial begin
    int w, lat, bz;
    exp_t e;
    vec_t alu_v[12];
    vec_t mul_v[4];
    alu_v = '{
      '{OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE},
      '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0},
      '{OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0},
      '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F},
      '{OP_SLL,  32'd1,        32'h00000023, 32'h00000008},
      '{OP_SLL,  32'd1,        32'h0000001F, 32'h80000000},
      '{OP_SRL,  32'h80000000, 32'd4,        32'h08000000},
      '{OP_SRA,  32'h80000000, 32'd4,        32'hF8000000},
      '{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001},
      '{OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000},
      '{OP_ADD,  32'd3,        32'd4,        32'h00000007},
      '{OP_SRA,  32'h7FFFFFF0, 32'h00000044, 32'h07FFFFFF}
    };
    mul_v = '{
      '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
      '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{OP_MUL,   32'd7,        32'd6,        32'h0000002A},
      '{OP_MULHU, 32'h80000000, 32'd4,        32'h00000002}
    };

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_outputs {rd,we,ill,wdata}", {out_rd, out_we, out_ill, out_wdata}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(OP_ADD, 32'h7FFFFFFF, 32'd1, 5'd1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0, w);
    wait_out(lat, bz);
    chk("add_latency", lat, 1);

    for (int i = 0; i < 12; i++) begin
      send(alu_v[i].op, alu_v[i].a, alu_v[i].b, 5'(i + 2), (i != 10), 1'b1,
           alu_v[i].r, (i != 10), 1'b0, w);
      chk("back_to_back_wait", w, 0);
    end
    drain();

    for (int i = 0; i < 4; i++) begin
      send(mul_v[i].op, mul_v[i].a, mul_v[i].b, 5'(20 + i), 1'b1, 1'b1,
           mul_v[i].r, 1'b1, 1'b0, w);
      wait_out(lat, bz);
      chk("mul_latency", lat, 17);
      chk("mul_busy_cycles", bz, 16);
      drain();
    end

`ifdef EX_ITER_DIV_EN
    send(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd11, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0, w);
    wait_out(lat, bz);
    chk("div_latency", lat, 33);
    chk("div_busy_cycles", bz, 32);
    drain();
    send(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd12, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, w);
    drain();
    send(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd13, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0, w);
    drain();
    send(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd14, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, w);
    drain();
    send(OP_DIVU, 32'd100, 32'd7, 5'd15, 1'b1, 1'b1, 32'd14, 1'b1, 1'b0, w);
    drain();
    send(OP_REMU, 32'd100, 32'd7, 5'd16, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, w);
    drain();
    send(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0, w);
    wait_out(lat, bz);
    chk("div_overflow_latency", lat, 1);
    drain();
    send(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd18, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, w);
    drain();
    send(OP_DIVU, 32'd5, 32'd0, 5'd19, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, w);
    wait_out(lat, bz);
    chk("div_by_zero_latency", lat, 1);
    drain();
    send(OP_REMU, 32'd5, 32'd0, 5'd20, 1'b1, 1'b1, 32'd5, 1'b1, 1'b0, w);
    drain();
`else
    send(OP_REMU, 32'd9, 32'd4, 5'd11, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, w);
    wait_out(lat, bz);
    chk("illegal_latency", lat, 1);
    drain();
    send(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd12, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, w);
    drain();
    send(OP_DIVU, 32'd5, 32'd0, 5'd13, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, w);
    wait_out(lat, bz);
    chk("illegal_divu0_latency", lat, 1);
    chk("illegal_busy", bz, 0);
    drain();
    send(OP_ADD, 32'd2, 32'd3, 5'd14, 1'b1, 1'b1, 32'd5, 1'b1, 1'b0, w);
    drain();
`endif

    // WB stall with a pending op, then consume and accept on the same edge.
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 5'd9, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, w);
    in_valid = 1'b1; op = OP_XOR; opa = 32'h0000FFFF; opb = 32'h00FF00FF; rd = 5'd10; rd_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_wdata", out_wdata, 32'd2);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    e.d = 32'h00FFFF00; e.rd = 5'd10; e.we = 1'b1; e.ill = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("release_reload_valid", out_valid, 1);
    chk("release_reload_wdata", out_wdata, 32'h00FFFF00);
    drain();

    flush_mid(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
`ifdef EX_ITER_DIV_EN
    flush_mid(OP_DIV, 32'd1000, 32'd3);
`endif

    // Reset in the middle of an iteration: nothing may come out afterwards.
    send(OP_MUL, 32'd3, 32'd5, 5'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0, w);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send(OP_ADD, 32'h11, 32'h22, 5'd5, 1'b1, 1'b1, 32'h33, 1'b1, 1'b0, w);
    wait_out(lat, bz);
    chk("post_reset_add_latency", lat, 1);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
